rv32i_wb_port_arb: RTL and testbench

//  Arbiter for the single register-file write port. Requesters are the in-order pipeline WB stage and
//  the long-latency multiply/divide unit (MDU). Sits between the WB stage and the dec-stage regfile.
//  MDU results wait in a small FIFO. Pipeline WB has priority; an anti-starvation counter forces an MDU

---
 rtl/rv32i_wb_port_arb_if.sv | 38 +++
 rtl/rv32i_wb_port_arb.sv | 144 ++++++++++++++
 tb/tb_rv32i_wb_port_arb.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_wb_port_arb_if.sv
// Bus bundle for the register-file write-port arbiter: pipeline WB request,
// MDU result handshake, hazard query and the regfile write port.
// master = the surrounding core (drives requests), slave = the arbiter.
interface rv32i_wb_port_arb_if #(
  parameter int WORD_WTH    = 32,
  parameter int REG_INX_WTH = 5
);
  logic                   wb_RegW_EN_i;
  logic [REG_INX_WTH-1:0] wb_rd_inx_i;
  logic [WORD_WTH-1:0]    wb_RegW_data_i;
  logic                   mdu_vld_i;
  logic                   mdu_rdy_o;
  logic [REG_INX_WTH-1:0] mdu_rd_inx_i;
  logic [WORD_WTH-1:0]    mdu_data_i;
  logic [REG_INX_WTH-1:0] rs1_inx_i;
  logic [REG_INX_WTH-1:0] rs2_inx_i;
  logic                   pend_hit_o;
  logic                   wb_stall_o;
  logic                   rf_we_o;
  logic [REG_INX_WTH-1:0] rf_waddr_o;
  logic [WORD_WTH-1:0]    rf_wdata_o;

  modport master (
    output wb_RegW_EN_i, wb_rd_inx_i, wb_RegW_data_i,
    output mdu_vld_i, mdu_rd_inx_i, mdu_data_i,
    output rs1_inx_i, rs2_inx_i,
    input  mdu_rdy_o, pend_hit_o, wb_stall_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o
  );

  modport slave (
    input  wb_RegW_EN_i, wb_rd_inx_i, wb_RegW_data_i,
    input  mdu_vld_i, mdu_rd_inx_i, mdu_data_i,
    input  rs1_inx_i, rs2_inx_i,
    output mdu_rdy_o, pend_hit_o, wb_stall_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o
  );
endinterface

// File: rtl/rv32i_wb_port_arb.sv
// Register-file write-port arbiter. The in-order pipeline WB stage has
// priority; MDU results wait in a small FIFO and are written when the
// pipeline is idle. If the pipeline keeps the port for STARVE_MAX cycles
// while a result waits, the next cycle is forced to the FIFO and the
// pipeline is stalled. Pending FIFO destinations are reported to the
// hazard unit so that WAW/RAW against queued results can be stalled.
// Optional feature macro: WB_ARB_STAT_EN adds a saturating forced-grant
// counter on stat_force_cnt_o.
module rv32i_wb_port_arb #(
  parameter int WORD_WTH    = 32,
  parameter int REG_INX_WTH = 5,
  parameter int FIFO_DEP    = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  rv32i_wb_port_arb_if.slave        bus
`ifdef WB_ARB_STAT_EN
  ,
  output logic [15:0]               stat_force_cnt_o
`endif
);

  localparam int PTR_WTH = $clog2(FIFO_DEP);
  localparam int CNT_WTH = PTR_WTH + 1;
  localparam int STV_WTH = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [REG_INX_WTH-1:0] rd;
    logic [WORD_WTH-1:0]    data;
  } entry_t;

  entry_t               mem [FIFO_DEP];
  logic [PTR_WTH-1:0]   rd_ptr;
  logic [PTR_WTH-1:0]   wr_ptr;
  logic [CNT_WTH-1:0]   count;
  logic [STV_WTH-1:0]   starve_cnt;
  logic                 force_q;

  logic                 empty;
  logic                 full;
  logic                 enq;
  logic                 store;
  logic                 pop;
  logic                 grant_fifo;
  logic                 denied;
  entry_t               head;
  logic [FIFO_DEP-1:0]  live;
  logic [FIFO_DEP-1:0]  hit;

  assign empty = (count == '0);
  assign full  = (count == CNT_WTH'(FIFO_DEP));
  assign head  = mem[rd_ptr];

  // An entry is accepted whenever there is room; rd=0 results are consumed
  // but never stored, since they could never write the regfile anyway.
  assign bus.mdu_rdy_o = !full;
  assign enq           = bus.mdu_vld_i & !full;
  assign store         = enq & (bus.mdu_rd_inx_i != '0);

  // Forced slot beats the pipeline; otherwise the FIFO only gets idle cycles.
  assign grant_fifo = force_q | (!bus.wb_RegW_EN_i & !empty);
  assign pop        = grant_fifo & !empty;
  assign denied     = !empty & !force_q & bus.wb_RegW_EN_i;

  assign bus.wb_stall_o = force_q;

  // Write-port mux: FIFO head when granted, otherwise pass the pipeline through
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    bus.rf_we_o    = bus.wb_RegW_EN_i & (bus.wb_rd_inx_i != '0);
    bus.rf_waddr_o = bus.wb_rd_inx_i;
    bus.rf_wdata_o = bus.wb_RegW_data_i;
    if (grant_fifo) begin
      bus.rf_we_o    = pop & (head.rd != '0);
      bus.rf_waddr_o = head.rd;
      bus.rf_wdata_o = head.data;
    end
  end

  // Hazard query over occupied slots only; the slot popped this cycle still counts
  always_comb begin
    live = '0;
    hit  = '0;
    for (int i = 0; i < FIFO_DEP; i++) begin
      live[i] = ({1'b0, PTR_WTH'(i) - rd_ptr} < count);
      hit[i]  = live[i] && (mem[i].rd != '0) &&
                ((mem[i].rd == bus.rs1_inx_i) || (mem[i].rd == bus.rs2_inx_i));
    end
  end

  assign bus.pend_hit_o = |hit;

  // MDU result FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the storage array is cleared as well, so a fresh reset never
      // exposes stale destinations to the hazard compare or the write port.
      for (int i = 0; i < FIFO_DEP; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) begin
        // NOTE: non-blocking assignments keep every state update in this
        // block reading the pre-edge values, whatever the statement order.
        mem[wr_ptr] <= '{rd: bus.mdu_rd_inx_i, data: bus.mdu_data_i};
        wr_ptr      <= wr_ptr + PTR_WTH'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_WTH'(1);
      count <= count + CNT_WTH'(store) - CNT_WTH'(pop);
    end
  end

  // Anti-starvation: count denied cycles, then reserve the next slot for the FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      force_q    <= 1'b0;
    end else if (pop) begin
      starve_cnt <= '0;
      force_q    <= 1'b0;
    end else if (denied) begin
      if (starve_cnt == STV_WTH'(STARVE_MAX - 1)) begin
        starve_cnt <= '0;
        force_q    <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + STV_WTH'(1);
      end
    end
  end

`ifdef WB_ARB_STAT_EN
  // Saturating count of forced grants
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_force_cnt_o <= '0;
    end else if (force_q && pop && (stat_force_cnt_o != 16'hFFFF)) begin
      stat_force_cnt_o <= stat_force_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_wb_port_arb.sv
// Directed bench for rv32i_wb_port_arb (FIFO_DEP=2, STARVE_MAX=4).
// Inputs change 1 time unit after the rising edge, outputs are sampled a
// few units later, well before the next rising edge.
module tb_rv32i_wb_port_arb;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rv32i_wb_port_arb_if #(.WORD_WTH(32), .REG_INX_WTH(5)) bus ();

`ifdef WB_ARB_STAT_EN
  logic [15:0] stat_force_cnt;
`endif

  rv32i_wb_port_arb #(
    .WORD_WTH(32), .REG_INX_WTH(5), .FIFO_DEP(2), .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef WB_ARB_STAT_EN
    ,
    .stat_force_cnt_o(stat_force_cnt)
`endif
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    bus.wb_RegW_EN_i   = en;
    bus.wb_rd_inx_i    = rd;
    bus.wb_RegW_data_i = data;
  endtask

  task automatic drive_mdu(input logic vld, input logic [4:0] rd, input logic [31:0] data);
    bus.mdu_vld_i    = vld;
    bus.mdu_rd_inx_i = rd;
    bus.mdu_data_i   = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_mdu(1'b0, 5'd0, 32'h0);
    bus.rs1_inx_i = 5'd0;
    bus.rs2_inx_i = 5'd0;
    #1 rst = 1'b0;
    settle();
    total++; if (bus.rf_we_o !== 1'b0) begin bad++; $display("FAIL reset_we: got %0b want 0", bus.rf_we_o); end
    total++; if (bus.mdu_rdy_o !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %0b want 1", bus.mdu_rdy_o); end
    total++; if (bus.wb_stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b want 0", bus.wb_stall_o); end
    total++; if (bus.pend_hit_o !== 1'b0) begin bad++; $display("FAIL reset_hit: got %0b want 0", bus.pend_hit_o); end
    drive_wb(1'b1, 5'd3, 32'h55);
    #1;
    total++; if (bus.rf_we_o !== 1'b1) begin bad++; $display("FAIL reset_pass_we: got %0b want 1", bus.rf_we_o); end
    total++; if (bus.rf_waddr_o !== 5'd3) begin bad++; $display("FAIL reset_pass_addr: got %0d want 3", bus.rf_waddr_o); end
    drive_wb(1'b0, 5'd0, 32'h0);
`ifdef WB_ARB_STAT_EN
    total++; if (stat_force_cnt !== 16'd0) begin bad++; $display("FAIL reset_stat: got %0d want 0", stat_force_cnt); end
`endif
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_rd_zero();
    drive_wb(1'b1, 5'd0, 32'hFF);
    settle();
    total++; if (bus.rf_we_o !== 1'b0) begin bad++; $display("FAIL rd0_drop: got %0b want 0", bus.rf_we_o); end
    drive_wb(1'b1, 5'd4, 32'h44);
    settle();
    total++; if (bus.rf_we_o !== 1'b1) begin bad++; $display("FAIL wb_we: got %0b want 1", bus.rf_we_o); end
    total++; if (bus.rf_wdata_o !== 32'h44) begin bad++; $display("FAIL wb_data: got %0h want 44", bus.rf_wdata_o); end
    drive_wb(1'b0, 5'd0, 32'h0);
    next_cycle();
  endtask

  task automatic test_mdu_idle();
    drive_mdu(1'b1, 5'd5, 32'h1234);
    bus.rs1_inx_i = 5'd5;
    settle();
    total++; if (bus.rf_we_o !== 1'b0) begin bad++; $display("FAIL idle_nobypass: got %0b want 0", bus.rf_we_o); end
    total++; if (bus.pend_hit_o !== 1'b0) begin bad++; $display("FAIL idle_hit_pre: got %0b want 0", bus.pend_hit_o); end
    next_cycle();
    drive_mdu(1'b0, 5'd0, 32'h0);
    settle();
    total++; if (bus.rf_we_o !== 1'b1) begin bad++; $display("FAIL idle_we: got %0b want 1", bus.rf_we_o); end
    total++; if (bus.rf_waddr_o !== 5'd5) begin bad++; $display("FAIL idle_addr: got %0d want 5", bus.rf_waddr_o); end
    total++; if (bus.rf_wdata_o !== 32'h1234) begin bad++; $display("FAIL idle_data: got %0h want 1234", bus.rf_wdata_o); end
    total++; if (bus.pend_hit_o !== 1'b1) begin bad++; $display("FAIL idle_hit_popping: got %0b want 1", bus.pend_hit_o); end
    next_cycle();
    settle();
    total++; if (bus.rf_we_o !== 1'b0) begin bad++; $display("FAIL idle_empty_we: got %0b want 0", bus.rf_we_o); end
    total++; if (bus.pend_hit_o !== 1'b0) begin bad++; $display("FAIL idle_empty_hit: got %0b want 0", bus.pend_hit_o); end
    bus.rs1_inx_i = 5'd0;
    next_cycle();
  endtask

  task automatic test_starve();
    drive_wb(1'b1, 5'd1, 32'hA0);
    drive_mdu(1'b1, 5'd9, 32'hBEEF);
    settle();
    total++; if (bus.rf_waddr_o !== 5'd1) begin bad++; $display("FAIL starve_enq_addr: got %0d want 1", bus.rf_waddr_o); end
    next_cycle();
    drive_mdu(1'b0, 5'd0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      drive_wb(1'b1, 5'(k + 1), 32'hA0 + 32'(k));
      settle();
      total++; if (bus.wb_stall_o !== 1'b0) begin bad++; $display("FAIL starve_deny%0d_stall: got %0b want 0", k, bus.wb_stall_o); end
      total++; if (bus.rf_waddr_o !== 5'(k + 1)) begin bad++; $display("FAIL starve_deny%0d_addr: got %0d want %0d", k, bus.rf_waddr_o, k + 1); end
      next_cycle();
    end
    drive_wb(1'b1, 5'd6, 32'hA5);
    settle();
    total++; if (bus.wb_stall_o !== 1'b1) begin bad++; $display("FAIL starve_force_stall: got %0b want 1", bus.wb_stall_o); end
    total++; if (bus.rf_we_o !== 1'b1) begin bad++; $display("FAIL starve_force_we: got %0b want 1", bus.rf_we_o); end
    total++; if (bus.rf_waddr_o !== 5'd9) begin bad++; $display("FAIL starve_force_addr: got %0d want 9", bus.rf_waddr_o); end
    total++; if (bus.rf_wdata_o !== 32'hBEEF) begin bad++; $display("FAIL starve_force_data: got %0h want beef", bus.rf_wdata_o); end
    next_cycle();
    settle();
    total++; if (bus.wb_stall_o !== 1'b0) begin bad++; $display("FAIL starve_after_stall: got %0b want 0", bus.wb_stall_o); end
    total++; if (bus.rf_waddr_o !== 5'd6) begin bad++; $display("FAIL starve_after_addr: got %0d want 6", bus.rf_waddr_o); end
`ifdef WB_ARB_STAT_EN
    total++; if (stat_force_cnt !== 16'd1) begin bad++; $display("FAIL starve_stat: got %0d want 1", stat_force_cnt); end
`endif
    drive_wb(1'b0, 5'd0, 32'h0);
    next_cycle();
  endtask

  task automatic test_full();
    drive_wb(1'b1, 5'd1, 32'h11);
    drive_mdu(1'b1, 5'd10, 32'd1);
    settle();
    total++; if (bus.mdu_rdy_o !== 1'b1) begin bad++; $display("FAIL full_a_rdy: got %0b want 1", bus.mdu_rdy_o); end
    next_cycle();
    drive_mdu(1'b1, 5'd11, 32'd2);
    settle();
    total++; if (bus.mdu_rdy_o !== 1'b1) begin bad++; $display("FAIL full_b_rdy: got %0b want 1", bus.mdu_rdy_o); end
    next_cycle();
    drive_mdu(1'b1, 5'd12, 32'd3);
    for (int k = 0; k < 3; k++) begin
      settle();
      total++; if (bus.mdu_rdy_o !== 1'b0) begin bad++; $display("FAIL full_hold%0d_rdy: got %0b want 0", k, bus.mdu_rdy_o); end
      next_cycle();
    end
    settle();
    total++; if (bus.wb_stall_o !== 1'b1) begin bad++; $display("FAIL full_force_stall: got %0b want 1", bus.wb_stall_o); end
    total++; if (bus.mdu_rdy_o !== 1'b0) begin bad++; $display("FAIL full_force_rdy: got %0b want 0", bus.mdu_rdy_o); end
    total++; if (bus.rf_waddr_o !== 5'd10) begin bad++; $display("FAIL full_force_addr: got %0d want 10", bus.rf_waddr_o); end
    total++; if (bus.rf_wdata_o !== 32'd1) begin bad++; $display("FAIL full_force_data: got %0h want 1", bus.rf_wdata_o); end
    next_cycle();
    settle();
    total++; if (bus.mdu_rdy_o !== 1'b1) begin bad++; $display("FAIL full_after_pop_rdy: got %0b want 1", bus.mdu_rdy_o); end
    total++; if (bus.rf_waddr_o !== 5'd1) begin bad++; $display("FAIL full_after_pop_addr: got %0d want 1", bus.rf_waddr_o); end
`ifdef WB_ARB_STAT_EN
    total++; if (stat_force_cnt !== 16'd2) begin bad++; $display("FAIL full_stat: got %0d want 2", stat_force_cnt); end
`endif
    next_cycle();
    drive_mdu(1'b0, 5'd0, 32'h0);
    drive_wb(1'b0, 5'd0, 32'h0);
    settle();
    total++; if (bus.rf_waddr_o !== 5'd11) begin bad++; $display("FAIL full_drain1_addr: got %0d want 11", bus.rf_waddr_o); end
    total++; if (bus.rf_wdata_o !== 32'd2) begin bad++; $display("FAIL full_drain1_data: got %0h want 2", bus.rf_wdata_o); end
    next_cycle();
    settle();
    total++; if (bus.rf_waddr_o !== 5'd12) begin bad++; $display("FAIL full_drain2_addr: got %0d want 12", bus.rf_waddr_o); end
    total++; if (bus.rf_wdata_o !== 32'd3) begin bad++; $display("FAIL full_drain2_data: got %0h want 3", bus.rf_wdata_o); end
    next_cycle();
    settle();
    total++; if (bus.rf_we_o !== 1'b0) begin bad++; $display("FAIL full_drained_we: got %0b want 0", bus.rf_we_o); end
    next_cycle();
  endtask

  task automatic test_pend_hit();
    drive_wb(1'b1, 5'd2, 32'h22);
    drive_mdu(1'b1, 5'd7, 32'h77);
    bus.rs1_inx_i = 5'd0;
    bus.rs2_inx_i = 5'd7;
    settle();
    total++; if (bus.pend_hit_o !== 1'b0) begin bad++; $display("FAIL hit_pre_store: got %0b want 0", bus.pend_hit_o); end
    next_cycle();
    drive_mdu(1'b0, 5'd0, 32'h0);
    settle();
    total++; if (bus.pend_hit_o !== 1'b1) begin bad++; $display("FAIL hit_rs2: got %0b want 1", bus.pend_hit_o); end
    bus.rs2_inx_i = 5'd3;
    #1;
    total++; if (bus.pend_hit_o !== 1'b0) begin bad++; $display("FAIL hit_miss: got %0b want 0", bus.pend_hit_o); end
    bus.rs1_inx_i = 5'd7;
    #1;
    total++; if (bus.pend_hit_o !== 1'b1) begin bad++; $display("FAIL hit_rs1: got %0b want 1", bus.pend_hit_o); end
    next_cycle();
    drive_wb(1'b0, 5'd0, 32'h0);
    bus.rs1_inx_i = 5'd0;
    bus.rs2_inx_i = 5'd0;
    settle();
    total++; if (bus.rf_waddr_o !== 5'd7) begin bad++; $display("FAIL hit_drain_addr: got %0d want 7", bus.rf_waddr_o); end
    next_cycle();
    drive_mdu(1'b1, 5'd0, 32'h99);
    settle();
    total++; if (bus.pend_hit_o !== 1'b0) begin bad++; $display("FAIL hit_rd0_enq: got %0b want 0", bus.pend_hit_o); end
    next_cycle();
    drive_mdu(1'b0, 5'd0, 32'h0);
    settle();
    total++; if (bus.pend_hit_o !== 1'b0) begin bad++; $display("FAIL hit_rd0_after: got %0b want 0", bus.pend_hit_o); end
    total++; if (bus.rf_we_o !== 1'b0) begin bad++; $display("FAIL rd0_discard_we: got %0b want 0", bus.rf_we_o); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    drive_wb(1'b1, 5'd1, 32'h1);
    drive_mdu(1'b1, 5'd20, 32'h20);
    next_cycle();
    drive_mdu(1'b1, 5'd21, 32'h21);
    next_cycle();
    drive_mdu(1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 3; k++) next_cycle();
    bus.rs1_inx_i = 5'd20;
    settle();
    total++; if (bus.wb_stall_o !== 1'b1) begin bad++; $display("FAIL mid_pre_stall: got %0b want 1", bus.wb_stall_o); end
    total++; if (bus.pend_hit_o !== 1'b1) begin bad++; $display("FAIL mid_pre_hit: got %0b want 1", bus.pend_hit_o); end
    drive_wb(1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    #1;
    total++; if (bus.wb_stall_o !== 1'b0) begin bad++; $display("FAIL mid_rst_stall: got %0b want 0", bus.wb_stall_o); end
    total++; if (bus.mdu_rdy_o !== 1'b1) begin bad++; $display("FAIL mid_rst_rdy: got %0b want 1", bus.mdu_rdy_o); end
    total++; if (bus.pend_hit_o !== 1'b0) begin bad++; $display("FAIL mid_rst_hit: got %0b want 0", bus.pend_hit_o); end
    total++; if (bus.rf_we_o !== 1'b0) begin bad++; $display("FAIL mid_rst_we: got %0b want 0", bus.rf_we_o); end
`ifdef WB_ARB_STAT_EN
    total++; if (stat_force_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_stat: got %0d want 0", stat_force_cnt); end
`endif
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      settle();
      total++; if (bus.rf_we_o !== 1'b0) begin bad++; $display("FAIL mid_post%0d_we: got %0b want 0", k, bus.rf_we_o); end
      next_cycle();
    end
    bus.rs1_inx_i = 5'd0;
  endtask

  initial begin
    test_reset();
    test_rd_zero();
    test_mdu_idle();
    test_starve();
    test_full();
    test_pend_hit();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
